// File: rtl/axi_llc_data_way_arb.sv
// axi_llc_data_way_arb
//
// Shares one LLC data way between NumReq cache units. Requests are granted
// round-robin. A grant is held (LOCKED) until a beat flagged `last` completes
// its handshake with the way. Read responses from the way are steered back to
// the unit named by the response's cache_unit tag.
//
// Payload layout: the request and response structs are carried as flat
// vectors. Their cache_unit field occupies the UNIT_W least significant bits.
// In the request struct, `we` sits at bit UNIT_W. The arbiter itself only
// rewrites cache_unit on requests and only reads it on responses.
//
// Ports
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   req_i               NumReq request payloads, unit i at [i*INP_W +: INP_W]
//   req_last_i          per-unit last-beat flag
//   req_valid_i         per-unit request valid
//   req_ready_o         per-unit request accepted (only the granted bit)
//   way_inp_o           request forwarded to the data way
//   way_valid_o         request valid towards the data way
//   way_ready_i         data way accepts the request
//   way_oup_i           read response from the data way
//   way_oup_valid_i     read response valid
//   way_oup_ready_o     read response consumed
//   rsp_o               response broadcast to all units
//   rsp_valid_o         one-hot response valid
//   rsp_ready_i         per-unit response ready
//   unit_err_o          pulse when a valid response carries a tag >= NumReq
module axi_llc_data_way_arb #(
  parameter int NumReq = 4,
  parameter int UNIT_W = 3,
  parameter int INP_W  = 16,
  parameter int OUP_W  = 35
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq*INP_W-1:0] req_i,
  input  logic [NumReq-1:0]       req_last_i,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  output logic [INP_W-1:0]        way_inp_o,
  output logic                    way_valid_o,
  input  logic                    way_ready_i,
  input  logic [OUP_W-1:0]        way_oup_i,
  input  logic                    way_oup_valid_i,
  output logic                    way_oup_ready_o,
  output logic [OUP_W-1:0]        rsp_o,
  output logic [NumReq-1:0]       rsp_valid_o,
  input  logic [NumReq-1:0]       rsp_ready_i,
  output logic                    unit_err_o
);

  localparam int IDX_W = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   lock_q, lock_d;
  logic [IDX_W-1:0]   gnt;
  logic               gnt_vld;
  logic               hs;
  logic               gnt_last;
  int                 idx;
  logic [INP_W-1:0]   inp;
  logic [UNIT_W-1:0]  rsp_unit;
  logic               rsp_in_range;

  // Successor of a requester index, wrapping at NumReq. With a single
  // requester the pointer never moves.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    if (NumReq == 1) return '0;
    return IDX_W'((int'(x) + 1) % NumReq);
  endfunction

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          if (hs && gnt_last) begin
            rr_d = wrap_inc(gnt);
          end else begin
            // Stalled first beat or start of a multi-beat sequence: the
            // presented request must not be retracted, so pin the grant.
            state_d = LOCKED;
            lock_d  = gnt;
          end
        end
      end
      LOCKED: begin
        if (hs && gnt_last) begin
          state_d = IDLE;
          rr_d    = wrap_inc(lock_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant selection and request forwarding
  always_comb begin
    gnt     = rr_q;
    gnt_vld = 1'b0;
    idx     = 0;
    if (state_q == LOCKED) begin
      gnt     = lock_q;
      gnt_vld = 1'b1;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        idx = (int'(rr_q) + k) % NumReq;
        if (!gnt_vld && req_valid_i[IDX_W'(idx)]) begin
          gnt     = IDX_W'(idx);
          gnt_vld = 1'b1;
        end
      end
    end

    inp               = req_i[int'(gnt)*INP_W +: INP_W];
    inp[UNIT_W-1:0]   = UNIT_W'(gnt);
    way_inp_o         = inp;
    way_valid_o       = !rst_i && gnt_vld && req_valid_i[gnt];
    gnt_last          = req_last_i[gnt];
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = !rst_i && gnt_vld && (int'(gnt) == i) && way_ready_i;
    end
  end

  assign hs = way_valid_o && way_ready_i;

  // Response steering; independent of the request side
  always_comb begin
    rsp_unit        = way_oup_i[UNIT_W-1:0];
    rsp_in_range    = int'(rsp_unit) < NumReq;
    rsp_o           = way_oup_i;
    // Out-of-range tags are dropped, so the way must not be stalled by them.
    way_oup_ready_o = !rsp_in_range;
    for (int i = 0; i < NumReq; i++) begin
      rsp_valid_o[i] = way_oup_valid_i && rsp_in_range && (int'(rsp_unit) == i);
      if (rsp_in_range && (int'(rsp_unit) == i)) begin
        way_oup_ready_o = rsp_ready_i[i];
      end
    end
    unit_err_o = !rst_i && way_oup_valid_i && !rsp_in_range;
  end

endmodule

// File: tb/tb_axi_llc_data_way_arb.sv
module tb_axi_llc_data_way_arb;

  localparam int N  = 4;
  localparam int UW = 3;
  localparam int IW = 16;
  localparam int OW = 35;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*IW-1:0] req;
  logic [N-1:0]    last, valid, rready;
  logic [N-1:0]    req_ready;
  logic [IW-1:0]   way_inp;
  logic            way_valid, wready;
  logic [OW-1:0]   oup;
  logic            ovalid, oready;
  logic [OW-1:0]   rsp;
  logic [N-1:0]    rsp_valid;
  logic            unit_err;

  // Expected response-side values for the next cycle, set by each scenario
  logic [N-1:0]    x_rv;
  logic            x_ordy, x_err;

  typedef struct {
    logic          wv;
    logic [IW-1:0] inp;
    logic [N-1:0]  rdy;
    logic [OW-1:0] rsp;
    logic [N-1:0]  rv;
    logic          ordy;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  axi_llc_data_way_arb #(
    .NumReq(N), .UNIT_W(UW), .INP_W(IW), .OUP_W(OW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_i           (req),
    .req_last_i      (last),
    .req_valid_i     (valid),
    .req_ready_o     (req_ready),
    .way_inp_o       (way_inp),
    .way_valid_o     (way_valid),
    .way_ready_i     (wready),
    .way_oup_i       (oup),
    .way_oup_valid_i (ovalid),
    .way_oup_ready_o (oready),
    .rsp_o           (rsp),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rready),
    .unit_err_o      (unit_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Request payload of unit u on a given beat; the tag field carries a bogus
  // value so that the arbiter's tag rewrite is observable.
  function automatic logic [IW-1:0] pay(input int u, input int beat, input logic we);
    return {12'(u * 256 + beat), we, 3'd7};
  endfunction

  // What the way should see when unit g is granted
  function automatic logic [IW-1:0] fwd(input int g, input int beat, input logic we);
    return {12'(g * 256 + beat), we, 3'(g)};
  endfunction

  // One clock cycle: drive payloads, queue the expectation, compare at the
  // falling edge, then return 1 time unit after the next rising edge.
  // g = -1 means no request is expected to reach the way.
  task automatic cyc(input int g, input int beat, input logic we);
    exp_t e;
    for (int u = 0; u < N; u++) req[u*IW +: IW] = pay(u, beat, we);
    e.wv   = (g >= 0);
    e.inp  = (g >= 0) ? fwd(g, beat, we) : '0;
    e.rdy  = (g >= 0 && wready) ? N'(1 << g) : '0;
    e.rsp  = oup;
    e.rv   = x_rv;
    e.ordy = x_ordy;
    e.err  = x_err;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check_eq("way_valid", 64'(way_valid), 64'(e.wv));
    if (e.wv) check_eq("way_inp", 64'(way_inp), 64'(e.inp));
    check_eq("req_ready", 64'(req_ready), 64'(e.rdy));
    check_eq("rsp_data", 64'(rsp), 64'(e.rsp));
    check_eq("rsp_valid", 64'(rsp_valid), 64'(e.rv));
    check_eq("way_oup_ready", 64'(oready), 64'(e.ordy));
    check_eq("unit_err", 64'(unit_err), 64'(e.err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with everything asserted, including a bad-tag response
    rst    = 1'b1;
    req    = '0;
    valid  = 4'b1111;
    last   = 4'b1111;
    wready = 1'b1;
    rready = 4'b1111;
    ovalid = 1'b1;
    oup    = {32'hDEAD_0006, 3'd6};
    x_rv   = 4'b0000;
    x_ordy = 1'b1;
    x_err  = 1'b0;
    #1;
    cyc(-1, 0, 1'b1);
    cyc(-1, 0, 1'b1);

    // Round-robin over units 1 and 3, single-beat
    rst    = 1'b0;
    ovalid = 1'b0;
    oup    = '0;
    valid  = 4'b1010;
    cyc(1, 0, 1'b1);
    cyc(3, 1, 1'b1);
    cyc(1, 2, 1'b1);
    cyc(3, 3, 1'b1);

    // Unit 0 four-beat sequence while unit 2 waits
    valid = 4'b0101;
    last  = 4'b0100;
    cyc(0, 0, 1'b1);
    cyc(0, 1, 1'b1);
    cyc(0, 2, 1'b1);
    last = 4'b0101;
    cyc(0, 3, 1'b1);
    cyc(2, 4, 1'b1);   // unit 0 now lowest priority
    valid = 4'b0000;
    cyc(-1, 0, 1'b1);

    // Stalled first beat keeps the grant on unit 1
    wready = 1'b0;
    valid  = 4'b0010;
    last   = 4'b1111;
    cyc(1, 0, 1'b1);
    valid = 4'b0011;
    cyc(1, 0, 1'b1);
    cyc(1, 0, 1'b1);
    wready = 1'b1;
    cyc(1, 0, 1'b1);
    valid = 4'b0001;
    cyc(0, 1, 1'b1);

    // Read from unit 2, response back-pressured for two cycles
    valid = 4'b0100;
    cyc(2, 5, 1'b0);
    valid  = 4'b0000;
    ovalid = 1'b1;
    oup    = {32'hCAFE_0002, 3'd2};
    rready = 4'b1011;
    x_rv   = 4'b0100;
    x_ordy = 1'b0;
    cyc(-1, 0, 1'b1);
    cyc(-1, 0, 1'b1);
    rready = 4'b1111;
    x_ordy = 1'b1;
    cyc(-1, 0, 1'b1);
    ovalid = 1'b0;
    oup    = '0;
    x_rv   = 4'b0000;
    cyc(-1, 0, 1'b1);

    // Out-of-range response tag is dropped and flagged
    ovalid = 1'b1;
    oup    = {32'h0BAD_0005, 3'd5};
    rready = 4'b0000;
    x_ordy = 1'b1;
    x_err  = 1'b1;
    cyc(-1, 0, 1'b1);
    ovalid = 1'b0;
    oup    = '0;
    rready = 4'b1111;
    x_err  = 1'b0;
    cyc(-1, 0, 1'b1);

    // Reset in the middle of unit 3's lock
    valid = 4'b1001;
    last  = 4'b0000;
    cyc(3, 0, 1'b1);
    cyc(3, 1, 1'b1);
    rst = 1'b1;
    cyc(-1, 2, 1'b1);
    rst = 1'b0;
    cyc(0, 0, 1'b1);
    last = 4'b0001;
    cyc(0, 1, 1'b1);
    last = 4'b0000;
    cyc(3, 2, 1'b1);
    valid = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
